// File: rtl/letc_core_stage_writeback_if.sv
// rtl/letc_core_stage_writeback_if.sv - forwarding source interface driven by a pipeline stage
interface letc_core_forwarder_if;
  logic        instr_produces_rd;
  logic [4:0]  rd_idx;
  logic        rd_val_avail;
  logic [31:0] rd_val;

  modport stage (
    output instr_produces_rd,
    output rd_idx,
    output rd_val_avail,
    output rd_val
  );

  modport consumer (
    input instr_produces_rd,
    input rd_idx,
    input rd_val_avail,
    input rd_val
  );
endinterface

// File: rtl/letc_core_stage_writeback.sv
// rtl/letc_core_stage_writeback.sv - LETC core writeback stage: load extraction, rd/CSR writes, forwarding, instret
package letc_core_pkg;
  typedef enum logic [1:0] {
    RD_SRC_ALU  = 2'd0,
    RD_SRC_CSR  = 2'd1,
    RD_SRC_MEM  = 2'd2,
    RD_SRC_RSVD = 2'd3
  } rd_src_e;

  typedef enum logic [1:0] {
    MEM_OP_NOP   = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2,
    MEM_OP_AMO   = 2'd3
  } mem_op_e;

  typedef enum logic [2:0] {
    SIZE_BYTE   = 3'd0,
    SIZE_HALF   = 3'd1,
    SIZE_WORD   = 3'd2,
    SIZE_BYTE_U = 3'd4,
    SIZE_HALF_U = 3'd5
  } mem_size_e;

  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef struct packed {
    logic [31:0] pc;
    rd_src_e     rd_src;
    logic [4:0]  rd_idx;
    logic        rd_we;
    logic        csr_expl_wen;
    logic [11:0] csr_idx;
    logic [31:0] csr_old_val;
    logic [31:0] csr_new_val;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    mem_op_e     mem_op;
    mem_size_e   mem_size;
    logic [31:0] mem_wdata;
`ifdef SIMULATION
    logic        sim_exit_req;
`endif
  } m2_to_w_s;
endpackage

module letc_core_stage_writeback
  import letc_core_pkg::*;
#(
  parameter logic [63:0] INSTRET_RST = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        w_ready,
  input  logic        w_flush,
  input  logic        w_stall,
  input  logic        m2_to_w_valid,
  input  m2_to_w_s    m2_to_w,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  letc_core_forwarder_if.stage w_forwarder,
  output logic [63:0] instret
`ifdef SIMULATION
  ,
  output logic        sim_exit
`endif
);

  logic        ff_in_valid;
  m2_to_w_s    ff_in;
  logic        out_valid;
  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;
  logic [31:0] rd_val;
  logic [63:0] instret_q;
  logic [63:0] instret_d;
  logic        unused_fields;

  assign w_ready = 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff_in_valid <= 1'b0;
    end else if (!w_stall) begin
      ff_in_valid <= m2_to_w_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!w_stall) begin
      ff_in <= m2_to_w;
    end
  end

  // rst_n gating keeps the reset cycle itself free of architectural writes
  assign out_valid = rst_n && ff_in_valid && !w_flush && !w_stall;

  assign off     = ff_in.alu_result[1:0];
  assign ld_byte = ff_in.mem_rdata[{off, 3'b000} +: 8];
  assign ld_half = ff_in.mem_rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    load_val = ff_in.mem_rdata;
    if (ff_in.mem_op != MEM_OP_AMO) begin
      case (ff_in.mem_size)
        SIZE_BYTE:   load_val = {{24{ld_byte[7]}}, ld_byte};
        SIZE_BYTE_U: load_val = {24'h0, ld_byte};
        SIZE_HALF:   load_val = {{16{ld_half[15]}}, ld_half};
        SIZE_HALF_U: load_val = {16'h0, ld_half};
        default:     load_val = ff_in.mem_rdata;
      endcase
    end
  end

  always_comb begin
    rd_val = 32'hDEADBEEF;
    case (ff_in.rd_src)
      RD_SRC_ALU: rd_val = ff_in.alu_result;
      RD_SRC_CSR: rd_val = ff_in.csr_old_val;
      RD_SRC_MEM: rd_val = load_val;
      default:    rd_val = 32'hDEADBEEF;
    endcase
  end

  assign rf_we     = out_valid && ff_in.rd_we && (ff_in.rd_idx != 5'd0);
  assign rf_waddr  = ff_in.rd_idx;
  assign rf_wdata  = rd_val;

  assign csr_we    = out_valid && ff_in.csr_expl_wen;
  assign csr_waddr = ff_in.csr_idx;
  assign csr_wdata = ff_in.csr_new_val;

  // Every value is final by writeback, so availability is unconditional
  assign w_forwarder.instr_produces_rd = ff_in_valid && ff_in.rd_we;
  assign w_forwarder.rd_idx            = ff_in.rd_idx;
  assign w_forwarder.rd_val_avail      = 1'b1;
  assign w_forwarder.rd_val            = rd_val;

  // A software write to either counter half replaces that cycle's increment
  always_comb begin
    instret_d = instret_q;
    if (csr_we && (csr_waddr == CSR_MINSTRET)) begin
      instret_d[31:0] = csr_wdata;
    end else if (csr_we && (csr_waddr == CSR_MINSTRETH)) begin
      instret_d[63:32] = csr_wdata;
    end else if (out_valid) begin
      instret_d = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret_q <= INSTRET_RST;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

  assign unused_fields = ^{ff_in.pc, ff_in.mem_wdata};

`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sim_exit <= 1'b0;
    end else if (out_valid && ff_in.sim_exit_req) begin
      sim_exit <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (out_valid && (ff_in.rd_src == RD_SRC_MEM) && (ff_in.mem_op != MEM_OP_AMO)) begin
      assert (!(((ff_in.mem_size == SIZE_HALF) || (ff_in.mem_size == SIZE_HALF_U)) && off[0]));
      assert (!((ff_in.mem_size == SIZE_WORD) && (off != 2'd0)));
    end
  end
`endif

endmodule

// File: tb/tb_letc_core_stage_writeback.sv
// tb/tb_letc_core_stage_writeback.sv - directed and randomized bench for the LETC writeback stage
module tb_letc_core_stage_writeback;
  import letc_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_ready;
  logic        w_flush;
  logic        w_stall;
  logic        m2_to_w_valid;
  m2_to_w_s    m2_to_w;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [63:0] instret;
`ifdef SIMULATION
  logic        sim_exit;
`endif

  int checks = 0;
  int failures = 0;
  logic [63:0] m_instret;

  letc_core_forwarder_if fwd ();

  always #5 clk = ~clk;

  letc_core_stage_writeback #(.INSTRET_RST(64'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .w_ready       (w_ready),
    .w_flush       (w_flush),
    .w_stall       (w_stall),
    .m2_to_w_valid (m2_to_w_valid),
    .m2_to_w       (m2_to_w),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .csr_we        (csr_we),
    .csr_waddr     (csr_waddr),
    .csr_wdata     (csr_wdata),
    .w_forwarder   (fwd),
    .instret       (instret)
`ifdef SIMULATION
    ,
    .sim_exit      (sim_exit)
`endif
  );

  function automatic m2_to_w_s mk_alu(input logic [4:0] rd, input logic [31:0] v);
    m2_to_w_s p;
    p = '0;
    p.rd_src = RD_SRC_ALU; p.rd_we = 1'b1; p.rd_idx = rd; p.alu_result = v;
    return p;
  endfunction

  function automatic m2_to_w_s mk_mem(input logic [4:0] rd, input mem_op_e op, input mem_size_e sz,
                                      input logic [31:0] addr, input logic [31:0] rdata);
    m2_to_w_s p;
    p = '0;
    p.rd_src = RD_SRC_MEM; p.rd_we = 1'b1; p.rd_idx = rd; p.mem_op = op; p.mem_size = sz;
    p.alu_result = addr; p.mem_rdata = rdata;
    return p;
  endfunction

  function automatic m2_to_w_s mk_csr(input logic [4:0] rd, input logic [11:0] idx,
                                      input logic [31:0] oldv, input logic [31:0] newv);
    m2_to_w_s p;
    p = '0;
    p.rd_src = RD_SRC_CSR; p.rd_we = 1'b1; p.rd_idx = rd; p.csr_expl_wen = 1'b1;
    p.csr_idx = idx; p.csr_old_val = oldv; p.csr_new_val = newv;
    return p;
  endfunction

  // Architectural result: the addressed lane shifted down, then extended by the load's signedness
  function automatic logic [31:0] ref_rd(input m2_to_w_s p);
    logic [31:0] w;
    int          s;
    w = p.mem_rdata >> (8 * p.alu_result[1:0]);
    case (p.rd_src)
      RD_SRC_ALU: return p.alu_result;
      RD_SRC_CSR: return p.csr_old_val;
      RD_SRC_MEM: begin
        if (p.mem_op == MEM_OP_AMO) return p.mem_rdata;
        case (p.mem_size)
          SIZE_BYTE:   begin s = $signed(w[7:0]);  return s; end
          SIZE_HALF:   begin s = $signed(w[15:0]); return s; end
          SIZE_BYTE_U: return w & 32'hFF;
          SIZE_HALF_U: return w & 32'hFFFF;
          default:     return p.mem_rdata;
        endcase
      end
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic logic [63:0] ref_instret(input logic [63:0] cur, input m2_to_w_s p);
    if (p.csr_expl_wen && p.csr_idx == 12'hB02) return {cur[63:32], p.csr_new_val};
    if (p.csr_expl_wen && p.csr_idx == 12'hB82) return {p.csr_new_val, cur[31:0]};
    return cur + 64'd1;
  endfunction

  function automatic m2_to_w_s rnd_payload();
    m2_to_w_s p;
    p = '0;
    p.pc          = $urandom;
    p.rd_src      = rd_src_e'($urandom_range(0, 3));
    p.rd_idx      = 5'($urandom_range(0, 31));
    p.rd_we       = 1'($urandom_range(0, 1));
    p.csr_expl_wen = ($urandom_range(0, 3) == 0);
    case ($urandom_range(0, 3))
      0:       p.csr_idx = 12'hB02;
      1:       p.csr_idx = 12'hB82;
      2:       p.csr_idx = 12'h340;
      default: p.csr_idx = 12'($urandom);
    endcase
    p.csr_old_val = $urandom;
    p.csr_new_val = $urandom;
    p.mem_rdata   = $urandom;
    p.mem_wdata   = $urandom;
    p.mem_op      = mem_op_e'($urandom_range(0, 3));
    case ($urandom_range(0, 4))
      0:       p.mem_size = SIZE_BYTE;
      1:       p.mem_size = SIZE_BYTE_U;
      2:       p.mem_size = SIZE_HALF;
      3:       p.mem_size = SIZE_HALF_U;
      default: p.mem_size = SIZE_WORD;
    endcase
    p.alu_result = $urandom;
    if (p.mem_size == SIZE_WORD) p.alu_result[1:0] = 2'b00;
    if (p.mem_size == SIZE_HALF || p.mem_size == SIZE_HALF_U) p.alu_result[0] = 1'b0;
`ifdef SIMULATION
    p.sim_exit_req = ($urandom_range(0, 63) == 0);
`endif
    return p;
  endfunction

  // Present one payload across a clock edge; on return it is held in the stage
  task automatic present(input logic v, input m2_to_w_s p);
    m2_to_w_valid = v;
    m2_to_w = p;
    @(posedge clk); #1;
    m2_to_w_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    present(1'b1, mk_alu(5'd3, 32'h11));
    present(1'b1, mk_alu(5'd3, 32'h11));
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%0b exp=0", rf_we); end
    rst_n = 1'b1; #1;
    checks++; if (instret !== 64'h0) begin failures++; $display("FAIL reset_instret got=%h exp=0", instret); end
    checks++; if (w_ready !== 1'b1) begin failures++; $display("FAIL reset_w_ready got=%0b exp=1", w_ready); end
    checks++; if (fwd.instr_produces_rd !== 1'b0) begin failures++; $display("FAIL reset_fwd_produces got=%0b exp=0", fwd.instr_produces_rd); end
    checks++; if (csr_we !== 1'b0) begin failures++; $display("FAIL reset_csr_we got=%0b exp=0", csr_we); end
`ifdef SIMULATION
    checks++; if (sim_exit !== 1'b0) begin failures++; $display("FAIL reset_sim_exit got=%0b exp=0", sim_exit); end
`endif
    present(1'b0, '0);
    m_instret = 64'h0;
  endtask

  task automatic test_loads();
    present(1'b1, mk_mem(5'd5, MEM_OP_LOAD, SIZE_BYTE, 32'h0000_1003, 32'h8012_3456));
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5) begin failures++; $display("FAIL lb_we got=%0b/%0d exp=1/5", rf_we, rf_waddr); end
    checks++; if (rf_wdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", rf_wdata); end
    present(1'b1, mk_mem(5'd5, MEM_OP_LOAD, SIZE_BYTE_U, 32'h0000_1003, 32'h8012_3456));
    checks++; if (rf_wdata !== 32'h0000_0080) begin failures++; $display("FAIL lbu_data got=%h exp=00000080", rf_wdata); end
    present(1'b1, mk_mem(5'd5, MEM_OP_LOAD, SIZE_HALF, 32'h0000_1002, 32'h8012_3456));
    checks++; if (rf_wdata !== 32'hFFFF_8012) begin failures++; $display("FAIL lh_data got=%h exp=ffff8012", rf_wdata); end
    present(1'b0, '0);
    m_instret = m_instret + 64'd3;
    checks++; if (instret !== m_instret) begin failures++; $display("FAIL loads_instret got=%h exp=%h", instret, m_instret); end
  endtask

  task automatic test_rd_zero();
    present(1'b1, mk_alu(5'd0, 32'd7));
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rd0_rf_we got=%0b exp=0", rf_we); end
    checks++; if (fwd.instr_produces_rd !== 1'b1) begin failures++; $display("FAIL rd0_fwd_produces got=%0b exp=1", fwd.instr_produces_rd); end
    present(1'b0, '0);
    m_instret = m_instret + 64'd1;
    checks++; if (instret !== m_instret) begin failures++; $display("FAIL rd0_instret got=%h exp=%h", instret, m_instret); end
  endtask

  task automatic test_back_to_back();
    m2_to_w_s    seq [3];
    logic [4:0]  got_idx [$];
    logic [31:0] got_dat [$];
    int          in_sel [7] = '{0, 1, 2, 2, 2, -1, -1};
    bit          stl [7]    = '{0, 0, 1, 1, 0, 0, 0};
    for (int i = 0; i < 3; i++) seq[i] = mk_alu(5'(i + 1), $urandom);
    for (int c = 0; c < 7; c++) begin
      w_stall = stl[c];
      m2_to_w_valid = (in_sel[c] >= 0);
      if (in_sel[c] >= 0) m2_to_w = seq[in_sel[c]];
      #1;
      if (rf_we) begin got_idx.push_back(rf_waddr); got_dat.push_back(rf_wdata); end
      @(posedge clk); #1;
    end
    w_stall = 1'b0; m2_to_w_valid = 1'b0;
    checks++; if (got_idx.size() != 3) begin failures++; $display("FAIL b2b_write_count got=%0d exp=3", got_idx.size()); end
    for (int i = 0; i < 3 && i < got_idx.size(); i++) begin
      checks++;
      if (got_idx[i] !== seq[i].rd_idx || got_dat[i] !== seq[i].alu_result) begin
        failures++; $display("FAIL b2b_write%0d got=%0d:%h exp=%0d:%h", i, got_idx[i], got_dat[i], seq[i].rd_idx, seq[i].alu_result);
      end
    end
    m_instret = m_instret + 64'd3;
    checks++; if (instret !== m_instret) begin failures++; $display("FAIL b2b_instret got=%h exp=%h", instret, m_instret); end
  endtask

  task automatic test_flush_csr();
    m2_to_w_s p;
    p = mk_csr(5'd6, 12'h340, 32'hAAAA_0001, 32'h1234_5678);
    present(1'b1, p);
    w_flush = 1'b1; #1;
    checks++; if (csr_we !== 1'b0 || rf_we !== 1'b0) begin failures++; $display("FAIL flush_writes got=%0b/%0b exp=0/0", csr_we, rf_we); end
    present(1'b1, mk_alu(5'd9, 32'h99));
    w_flush = 1'b0; #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99) begin
      failures++; $display("FAIL flush_next got=%0b/%0d/%h exp=1/9/00000099", rf_we, rf_waddr, rf_wdata);
    end
    present(1'b0, '0);
    m_instret = m_instret + 64'd1;
    checks++; if (instret !== m_instret) begin failures++; $display("FAIL flush_instret got=%h exp=%h", instret, m_instret); end
    present(1'b1, p);
    checks++; if (csr_we !== 1'b1 || csr_waddr !== 12'h340 || csr_wdata !== 32'h1234_5678) begin
      failures++; $display("FAIL csr_write got=%0b/%h/%h exp=1/340/12345678", csr_we, csr_waddr, csr_wdata);
    end
    checks++; if (rf_wdata !== 32'hAAAA_0001) begin failures++; $display("FAIL csr_rd_val got=%h exp=aaaa0001", rf_wdata); end
    present(1'b0, '0);
    m_instret = m_instret + 64'd1;
  endtask

  task automatic test_instret_wrap();
    present(1'b1, mk_csr(5'd0, 12'hB82, 32'h0, 32'hFFFF_FFFF));
    present(1'b1, mk_csr(5'd0, 12'hB02, 32'h0, 32'hFFFF_FFFF));
    present(1'b1, mk_alu(5'd1, 32'h1));
    present(1'b0, '0);
    checks++; if (instret !== 64'h0) begin failures++; $display("FAIL instret_wrap64 got=%h exp=0", instret); end
    present(1'b1, mk_csr(5'd0, 12'hB82, 32'h0, 32'h0));
    present(1'b1, mk_csr(5'd0, 12'hB02, 32'h0, 32'hFFFF_FFFF));
    present(1'b1, mk_alu(5'd1, 32'h1));
    present(1'b0, '0);
    checks++; if (instret !== 64'h0000_0001_0000_0000) begin failures++; $display("FAIL instret_carry got=%h exp=0000000100000000", instret); end
    present(1'b1, mk_csr(5'd0, 12'hB02, 32'h0, 32'h10));
    present(1'b0, '0);
    checks++; if (instret !== 64'h0000_0001_0000_0010) begin failures++; $display("FAIL instret_csrw got=%h exp=0000000100000010", instret); end
    m_instret = 64'h0000_0001_0000_0010;
  endtask

  task automatic test_amo_reset();
    present(1'b1, mk_mem(5'd7, MEM_OP_AMO, SIZE_WORD, 32'h0000_2004, 32'h5));
    w_stall = 1'b1; #1;
    checks++; if (rf_wdata !== 32'h5) begin failures++; $display("FAIL amo_data got=%h exp=00000005", rf_wdata); end
    checks++; if (fwd.rd_val_avail !== 1'b1 || fwd.rd_val !== 32'h5 || fwd.rd_idx !== 5'd7 || fwd.instr_produces_rd !== 1'b1) begin
      failures++; $display("FAIL amo_fwd got=%0b/%h/%0d/%0b exp=1/00000005/7/1", fwd.rd_val_avail, fwd.rd_val, fwd.rd_idx, fwd.instr_produces_rd);
    end
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL amo_stalled_we got=%0b exp=0", rf_we); end
    rst_n = 1'b0; w_stall = 1'b0; #1;
    checks++; if (rf_we !== 1'b0 || csr_we !== 1'b0) begin failures++; $display("FAIL rst_cycle_writes got=%0b/%0b exp=0/0", rf_we, csr_we); end
    @(posedge clk); #1;
    checks++; if (fwd.instr_produces_rd !== 1'b0 || rf_we !== 1'b0) begin failures++; $display("FAIL rst_discard got=%0b/%0b exp=0/0", fwd.instr_produces_rd, rf_we); end
    checks++; if (instret !== 64'h0) begin failures++; $display("FAIL rst_instret got=%h exp=0", instret); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rst_after_we got=%0b exp=0", rf_we); end
    m_instret = 64'h0;
  endtask

  task automatic test_random();
    m2_to_w_s held, nxt;
    logic     held_v, stall, flush, v, retire, exp_we, exp_cwe;
    logic     m_exit;
    held = '0; held_v = 1'b0; m_exit = 1'b0;
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 5) == 0);
      flush = !stall && ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 3) != 0);
      nxt = rnd_payload();
      w_stall = stall; w_flush = flush; m2_to_w_valid = v; m2_to_w = nxt;
      #1;
      retire  = held_v && !stall && !flush;
      exp_we  = retire && held.rd_we && (held.rd_idx != 5'd0);
      exp_cwe = retire && held.csr_expl_wen;
      checks++; if (rf_we !== exp_we) begin failures++; $display("FAIL rnd_rf_we cyc=%0d got=%0b exp=%0b", c, rf_we, exp_we); end
      if (exp_we) begin
        checks++; if (rf_waddr !== held.rd_idx || rf_wdata !== ref_rd(held)) begin
          failures++; $display("FAIL rnd_rf_write cyc=%0d got=%0d:%h exp=%0d:%h", c, rf_waddr, rf_wdata, held.rd_idx, ref_rd(held));
        end
      end
      checks++; if (csr_we !== exp_cwe) begin failures++; $display("FAIL rnd_csr_we cyc=%0d got=%0b exp=%0b", c, csr_we, exp_cwe); end
      if (exp_cwe) begin
        checks++; if (csr_waddr !== held.csr_idx || csr_wdata !== held.csr_new_val) begin
          failures++; $display("FAIL rnd_csr_write cyc=%0d got=%h:%h exp=%h:%h", c, csr_waddr, csr_wdata, held.csr_idx, held.csr_new_val);
        end
      end
      checks++; if (fwd.instr_produces_rd !== (held_v && held.rd_we)) begin
        failures++; $display("FAIL rnd_fwd_produces cyc=%0d got=%0b exp=%0b", c, fwd.instr_produces_rd, held_v && held.rd_we);
      end
      if (held_v) begin
        checks++; if (fwd.rd_val !== ref_rd(held) || fwd.rd_idx !== held.rd_idx || fwd.rd_val_avail !== 1'b1) begin
          failures++; $display("FAIL rnd_fwd_val cyc=%0d got=%h:%0d exp=%h:%0d", c, fwd.rd_val, fwd.rd_idx, ref_rd(held), held.rd_idx);
        end
      end
      checks++; if (instret !== m_instret) begin failures++; $display("FAIL rnd_instret cyc=%0d got=%h exp=%h", c, instret, m_instret); end
`ifdef SIMULATION
      checks++; if (sim_exit !== m_exit) begin failures++; $display("FAIL rnd_sim_exit cyc=%0d got=%0b exp=%0b", c, sim_exit, m_exit); end
      if (retire && held.sim_exit_req) m_exit = 1'b1;
`endif
      if (retire) m_instret = ref_instret(m_instret, held);
      if (!stall) begin held_v = v; held = nxt; end
      @(posedge clk); #1;
    end
    w_stall = 1'b0; w_flush = 1'b0; m2_to_w_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; w_flush = 1'b0; w_stall = 1'b0; m2_to_w_valid = 1'b0; m2_to_w = '0;
    m_instret = 64'h0;
    @(posedge clk); #1;
    test_reset();
    test_loads();
    test_rd_zero();
    test_back_to_back();
    test_flush_csr();
    test_instret_wrap();
    test_amo_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/letc_core_stage_writeback.md
Name: letc_core_stage_writeback

Overview:
Final LETC core pipeline stage. It consumes m2_to_w from Memory 2 and performs load-data alignment and extension. It selects the rd value, drives the integer register file write port and the explicit CSR write port, and forwards the retiring rd value to earlier stages. It also owns the 64-bit retired-instruction counter backing minstret/minstreth.

Parameters:
INSTRET_RST, 64'h0, reset value of the retired-instruction counter.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
w_ready  output  1  stage can accept; constant 1
w_flush  input  1  kill instruction currently held in stage
w_stall  input  1  hold input register, suppress retirement
m2_to_w_valid  input  1  upstream payload valid
m2_to_w  input  m2_to_w_s  upstream payload (pc, rd_src, rd_idx, rd_we, csr_expl_wen, csr_idx, csr_old_val, csr_new_val, alu_result, mem_rdata, mem_op, mem_size, mem_wdata, sim_exit_req under SIMULATION)
rf_we  output  1  register file write enable
rf_waddr  output  5  register file write index
rf_wdata  output  32  register file write data
csr_we  output  1  explicit CSR write enable
csr_waddr  output  12  CSR index
csr_wdata  output  32  CSR write data
w_forwarder  letc_core_forwarder_if.stage  -  forwarding source
instret  output  64  retired-instruction count
sim_exit  output  1  (SIMULATION only) registered exit request

Behaviour:
Input register
- ff_in_valid: reset 0; loads m2_to_w_valid when !w_stall.
- ff_in: loads m2_to_w when !w_stall. Not reset.
- out_valid = ff_in_valid && !w_flush && !w_stall. This is the single retire qualifier.

Load extraction
- Combinational; off = ff_in.alu_result[1:0].
- Byte sizes: lane = mem_rdata[8*off +: 8].
- Half sizes: lane = mem_rdata[16*off[1] +: 16].
- Word: full mem_rdata.
- Signed variants sign-extend the lane; _U variants zero-extend.
- Half with off[0]=1 or word with off!=0: out of contract (assertion fires under SIMULATION); data is don't-care.
- MEM_OP_AMO: load value is the unextended mem_rdata word.

rd value
- RD_SRC_ALU: alu_result.
- RD_SRC_CSR: csr_old_val.
- RD_SRC_MEM: extracted load value.
- Other encodings: 32'hDEADBEEF.

Register file write
- rf_we = out_valid && rd_we && (rd_idx != 0).
- rf_waddr = rd_idx; rf_wdata = rd value.

CSR write
- csr_we = out_valid && csr_expl_wen.
- csr_waddr = csr_idx; csr_wdata = csr_new_val.

Forwarder
- instr_produces_rd = ff_in_valid && rd_we.
- rd_idx = ff_in.rd_idx; rd_val_avail = 1 (all values final here); rd_val = rd value.

instret counter
- 64-bit; reset INSTRET_RST.
- Each cycle with out_valid: +1, wrapping 64'hFFFF_FFFF_FFFF_FFFF -> 0.
- If csr_we with csr_waddr 12'hB02: low 32 bits := csr_wdata, high unchanged, no increment that cycle.
- If csr_we with csr_waddr 12'hB82: high 32 bits := csr_wdata, low unchanged, no increment that cycle.
- instret output is the registered value; one-cycle latency from retirement.

sim_exit
- Reset 0; set on out_valid && sim_exit_req; sticky until reset.

Flush/stall interaction
- Flush and stall both suppress all side effects: rf_we, csr_we, counter increment, sim_exit.
- Flush without stall: the next m2_to_w is still captured.

Reset mid-operation
- Held instruction discarded; no writes in the reset cycle or the cycle after.

Test Plan:
- LB from addr ...3, mem_rdata 32'h80_12_34_56, rd_idx 5 -> rf_we=1, rf_waddr=5, rf_wdata=32'hFFFF_FF80. LBU same -> 32'h0000_0080. LH off=2 -> 32'hFFFF_8012.
- ALU op with rd_idx 0, alu_result 7 -> rf_we=0; instret still increments by 1.
- Back-to-back 3 valid instrs, w_stall high on 2nd cycle for 2 cycles -> exactly 3 rf writes, instret +3, stalled instr retires once.
- w_flush with a valid CSRRW to 0x340 held -> csr_we=0, rf_we=0, instret unchanged. Next instr retires normally.
- instret at 64'h0000_0000_FFFF_FFFF, one retire -> 64'h0000_0001_0000_0000. Then CSRW minstret (0xB02) with 32'h10 -> instret = 64'h0000_0001_0000_0010, no extra +1.
- AMOADD with mem_rdata 32'h5 -> rf_wdata=5. Forwarder shows rd_val_avail=1, rd_val=5 while held. rst_n low mid-stall -> ff_in_valid=0, instret=0, no writes.
